// File: rtl/data_mem_sized_if.sv
// data_mem_sized_if: request/response bus of the MEM-stage data memory.
//   req_valid/req_we/req_addr/req_size/req_unsigned/req_wdata : request (master -> slave)
//   ready                                                      : slave can accept a request
//   rsp_valid/rsp_rdata/rsp_err                                : one-cycle response (slave -> master)
interface data_mem_sized_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              ready;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_sized.sv
// data_mem_sized: byte-addressed little-endian data memory, DEPTH bytes stored
// as DEPTH/4 words of 4 byte lanes. Byte/halfword/word loads and stores, sign or
// zero extension on sub-word loads, one-cycle registered response. After reset
// the array is cleared one word per clock before ready is raised.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of data_mem_sized_if (request in, ready/response out)
module data_mem_sized #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  data_mem_sized_if.slave    bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned WORDS = DEPTH / 4;
  localparam int unsigned IW    = AW - 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  logic [IW-1:0]   clear_idx;
  logic            ready_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic [1:0]      rsp_err_q;

  logic [31:0]     mem [WORDS];

  logic [1:0]      lane;
  logic [IW-1:0]   idx;
  logic [2:0]      nbytes;
  logic [ADDR_W:0] limit;
  logic [1:0]      err;
  logic            accept;
  logic            wr_en;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     ldata;

  assign bus.ready     = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_comb begin
    lane   = bus.req_addr[1:0];
    idx    = bus.req_addr[AW-1:2];
    accept = bus.req_valid && ready_q;

    // Illegal size 11 is range-checked as a 4-byte access.
    unique case (bus.req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    // Compare one bit wider than the address so the limit never wraps.
    limit  = (ADDR_W+1)'(DEPTH) - (ADDR_W+1)'(nbytes);
    err[1] = {1'b0, bus.req_addr} > limit;
    err[0] = (bus.req_size == 2'b11) ||
             ((bus.req_size == 2'b01) && lane[0]) ||
             ((bus.req_size == 2'b10) && (lane != 2'b00));

    wr_en = accept && bus.req_we && (err == 2'b00);

    // Replicate store data across lanes; byte enables pick the live lanes.
    be = 4'b0000;
    wd = '0;
    unique case (bus.req_size)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        be = 4'b1111;
        wd = bus.req_wdata;
      end
      default: begin
        be = 4'b0000;
        wd = '0;
      end
    endcase

    rword = mem[idx];
    rbyte = rword[{lane, 3'b000} +: 8];
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    unique case (bus.req_size)
      2'b00:   ldata = bus.req_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   ldata = bus.req_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: ldata = rword;
    endcase
  end

  // Storage has no reset; INIT clears it one word per clock instead.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clear_idx] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wd[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      clear_idx   <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 2'b00;
    end else begin
      unique case (state)
        INIT: begin
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 2'b00;
          clear_idx   <= clear_idx + 1'b1;
          if (clear_idx == IW'(WORDS - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          rsp_valid_q <= accept;
          rsp_err_q   <= accept ? err : 2'b00;
          rsp_rdata_q <= (accept && !bus.req_we && (err == 2'b00)) ? ldata : '0;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_sized.sv
module tb_data_mem_sized;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  data_mem_sized_if #(.ADDR_W(32)) bus ();

  data_mem_sized #(.ADDR_W(32), .DEPTH(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present a request and return at the next negedge, when its response is visible.
  task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wd;
    @(negedge clk);
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] rd, input logic [1:0] err);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rdata"}, bus.rsp_rdata, rd);
    check({tag, "_err"},   32'(bus.rsp_err), 32'(err));
  endtask

  task automatic hold_store_all_ones();
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_addr     = 32'h0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'hFFFF_FFFF;
  endtask

  // Called at the negedge where rst_n was released; expects ready after 32 edges.
  task automatic wait_ready(input string tag);
    int   rdy_at;
    logic seen_rsp;
    rdy_at   = 0;
    seen_rsp = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp = 1'b1;
      if (bus.ready) begin
        rdy_at = k;
        break;
      end
    end
    bus.req_valid = 1'b0;
    check({tag, "_ready_cycle"}, 32'(rdy_at), 32'd32);
    check({tag, "_no_rsp"}, 32'(seen_rsp), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    hold_store_all_ones();
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rdata", bus.rsp_rdata, 32'h0);
    check("reset_err", 32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;
    wait_ready("init");

    send(1'b0, 32'd0, 2'b10, 1'b0, 32'h0);          expect_rsp("ld0_cleared", 32'h0, 2'b00);

    send(1'b1, 32'd8, 2'b10, 1'b0, 32'hDEAD_BEEF);  expect_rsp("st_w8", 32'h0, 2'b00);
    send(1'b0, 32'd8, 2'b10, 1'b0, 32'h0);          expect_rsp("ld_w8", 32'hDEAD_BEEF, 2'b00);
    send(1'b0, 32'd9, 2'b00, 1'b1, 32'h0);          expect_rsp("ld_bu9", 32'h0000_00BE, 2'b00);
    send(1'b0, 32'd9, 2'b00, 1'b0, 32'h0);          expect_rsp("ld_bs9", 32'hFFFF_FFBE, 2'b00);
    send(1'b0, 32'd10, 2'b01, 1'b0, 32'h0);         expect_rsp("ld_hs10", 32'hFFFF_DEAD, 2'b00);
    send(1'b0, 32'd10, 2'b01, 1'b1, 32'h0);         expect_rsp("ld_hu10", 32'h0000_DEAD, 2'b00);
    send(1'b0, 32'd8, 2'b01, 1'b0, 32'h0);          expect_rsp("ld_hs8", 32'hFFFF_BEEF, 2'b00);

    send(1'b1, 32'd12, 2'b10, 1'b0, 32'hAABB_CCDD); expect_rsp("st_w12", 32'h0, 2'b00);
    send(1'b1, 32'd13, 2'b00, 1'b0, 32'hFFFF_FF11); expect_rsp("st_b13", 32'h0, 2'b00);
    send(1'b0, 32'd12, 2'b10, 1'b0, 32'h0);         expect_rsp("ld_w12_b", 32'hAABB_11DD, 2'b00);
    send(1'b1, 32'd14, 2'b01, 1'b0, 32'h9999_2233); expect_rsp("st_h14", 32'h0, 2'b00);
    send(1'b0, 32'd12, 2'b10, 1'b0, 32'h0);         expect_rsp("ld_w12_h", 32'h2233_11DD, 2'b00);

    send(1'b1, 32'd6, 2'b10, 1'b0, 32'hFFFF_FFFF);  expect_rsp("err_st_w6", 32'h0, 2'b01);
    send(1'b0, 32'd4, 2'b10, 1'b0, 32'h0);          expect_rsp("after_err_w4", 32'h0, 2'b00);
    send(1'b0, 32'd8, 2'b10, 1'b0, 32'h0);          expect_rsp("after_err_w8", 32'hDEAD_BEEF, 2'b00);
    send(1'b0, 32'd127, 2'b01, 1'b0, 32'h0);        expect_rsp("err_ld_h127", 32'h0, 2'b11);
    send(1'b0, 32'd128, 2'b10, 1'b0, 32'h0);        expect_rsp("err_ld_w128", 32'h0, 2'b10);
    send(1'b1, 32'd0, 2'b11, 1'b0, 32'hFFFF_FFFF);  expect_rsp("err_size3", 32'h0, 2'b01);
    send(1'b0, 32'd0, 2'b10, 1'b0, 32'h0);          expect_rsp("after_size3_w0", 32'h0, 2'b00);
    send(1'b0, 32'd128, 2'b00, 1'b0, 32'h0);        expect_rsp("err_ld_b128", 32'h0, 2'b10);
    send(1'b0, 32'd125, 2'b10, 1'b0, 32'h0);        expect_rsp("err_ld_w125", 32'h0, 2'b11);
    send(1'b1, 32'hFFFF_FFFC, 2'b10, 1'b0, 32'h1);  expect_rsp("err_st_far", 32'h0, 2'b10);

    send(1'b1, 32'd127, 2'b00, 1'b0, 32'h0000_0080); expect_rsp("st_b127", 32'h0, 2'b00);
    send(1'b0, 32'd127, 2'b00, 1'b0, 32'h0);         expect_rsp("ld_bs127", 32'hFFFF_FF80, 2'b00);
    send(1'b0, 32'd126, 2'b01, 1'b1, 32'h0);         expect_rsp("ld_hu126", 32'h0000_8000, 2'b00);
    send(1'b0, 32'd124, 2'b10, 1'b0, 32'h0);         expect_rsp("ld_w124", 32'h8000_0000, 2'b00);

    bus.req_valid = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'(bus.rsp_valid), 32'd0);
    check("idle_rdata", bus.rsp_rdata, 32'h0);
    check("idle_err", 32'(bus.rsp_err), 32'd0);

    send(1'b1, 32'd4, 2'b10, 1'b0, 32'h1234_5678);  expect_rsp("pipe_st", 32'h0, 2'b00);
    send(1'b0, 32'd4, 2'b10, 1'b0, 32'h0);          expect_rsp("pipe_ld", 32'h1234_5678, 2'b00);

    // Reset while running: outputs drop without waiting for a clock.
    send(1'b0, 32'd8, 2'b10, 1'b0, 32'h0);          expect_rsp("pre_rst_ld", 32'hDEAD_BEEF, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    check("run_rst_ready", 32'(bus.ready), 32'd0);
    check("run_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("run_rst_rdata", bus.rsp_rdata, 32'h0);
    hold_store_all_ones();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_init_ready", 32'(bus.ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("reinit");

    send(1'b0, 32'd8, 2'b10, 1'b0, 32'h0);          expect_rsp("reinit_w8", 32'h0, 2'b00);
    send(1'b0, 32'd0, 2'b10, 1'b0, 32'h0);          expect_rsp("reinit_w0", 32'h0, 2'b00);
    bus.req_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
